riscv_fetch_buffer: RTL

Parametrised instruction-fetch front end for the next-generation RISC-V core. It replaces the bare PC-register-plus-table-lookup with a prefetching fetch unit: a PC register and an instruction-table read feed a FIFO. The block exposes a valid/ready instruction stream to decode and accepts branch/jump redirects that flush in-flight entries. It sits between the program table and the decode stage (regfile, immediate generator, control logic).

---
 rtl/riscv_fetch_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/riscv_fetch_buffer.sv
// Prefetching instruction-fetch front end: PC register plus table lookup feeding a
// FIFO. Decode gets a valid/ready stream; taken redirects flush the buffer.
module riscv_fetch_buffer #(
  parameter int unsigned         XLEN       = 32,
  parameter int unsigned         N_INST     = 21,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0]     RESET_PC   = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_INST-1:0][31:0]         tab_inst,
  input  logic                            fetch_en_i,
  input  logic                            redirect_i,
  input  logic [XLEN-1:0]                 redirect_pc_i,
  input  logic                            inst_ready_i,
  output logic                            inst_valid_o,
  output logic [31:0]                     inst_o,
  output logic [XLEN-1:0]                 pc_o,
  output logic [XLEN-1:0]                 pc_4_o,
  output logic                            fault_o,
  output logic [$clog2(FIFO_DEPTH):0]     occupancy_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = (N_INST > 1) ? $clog2(N_INST) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mem_pc_q    [FIFO_DEPTH];
  logic [XLEN-1:0] mem_pc_d    [FIFO_DEPTH];
  logic [31:0]     mem_inst_q  [FIFO_DEPTH];
  logic [31:0]     mem_inst_d  [FIFO_DEPTH];
  logic            mem_fault_q [FIFO_DEPTH];
  logic            mem_fault_d [FIFO_DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            vld_q, vld_d;
  logic [31:0]     inst_out_q, inst_out_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            fault_out_q, fault_out_d;

  logic [XLEN-1:0] idx;
  logic            lk_fault;
  logic [31:0]     lk_inst;
  logic            pop, push;

  // Table lookup at the fetch PC; misaligned or past-the-end fetches yield a faulted NOP.
  always_comb begin
    idx      = pc_q >> 2;
    lk_fault = (pc_q[1:0] != 2'b00) || (idx >= XLEN'(N_INST));
    lk_inst  = lk_fault ? NOP : tab_inst[idx[IW-1:0]];
  end

  // FIFO and PC next state; the head outputs are re-registered from the next state.
  always_comb begin
    pc_d        = pc_q;
    mem_pc_d    = mem_pc_q;
    mem_inst_d  = mem_inst_q;
    mem_fault_d = mem_fault_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    count_d     = count_q;

    pop  = vld_q & inst_ready_i;
    push = fetch_en_i & ~redirect_i & ((count_q < CW'(FIFO_DEPTH)) | pop);

    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_q]    = pc_q;
        mem_inst_d[wr_q]  = lk_inst;
        mem_fault_d[wr_q] = lk_fault;
        wr_d              = wr_q + PW'(1);
        pc_d              = pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    vld_d       = (count_d != '0);
    inst_out_d  = NOP;
    pc_out_d    = '0;
    fault_out_d = 1'b0;
    if (vld_d) begin
      inst_out_d  = mem_inst_d[rd_d];
      pc_out_d    = mem_pc_d[rd_d];
      fault_out_d = mem_fault_d[rd_d];
    end
    pc4_d = pc_out_d + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      vld_q       <= 1'b0;
      inst_out_q  <= NOP;
      pc_out_q    <= '0;
      pc4_q       <= XLEN'(4);
      fault_out_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_inst_q[i]  <= NOP;
        mem_fault_q[i] <= 1'b0;
      end
    end else begin
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      vld_q       <= vld_d;
      inst_out_q  <= inst_out_d;
      pc_out_q    <= pc_out_d;
      pc4_q       <= pc4_d;
      fault_out_q <= fault_out_d;
      mem_pc_q    <= mem_pc_d;
      mem_inst_q  <= mem_inst_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  assign inst_valid_o = vld_q;
  assign inst_o       = inst_out_q;
  assign pc_o         = pc_out_q;
  assign pc_4_o       = pc4_q;
  assign fault_o      = fault_out_q;
  assign occupancy_o  = count_q;

endmodule
